// File: rtl/w_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | w_serial_tx : frames a parallel word on w as preamble 1s, MSB-first data, |
// |               then trailing 0s.                Revision: 1.0             |
// +--------------------------------------------------------------------------+
module w_serial_tx #(
  parameter int DATA_W  = 8,
  parameter int PRE_LEN = 2,
  parameter int GAP_LEN = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              w,
  output logic [1:0]        State,
  output logic              done
);

  localparam int MAX_PD  = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int MAX_LEN = (MAX_PD > GAP_LEN) ? MAX_PD : GAP_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] C_PRE  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] C_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    DATA = 2'b10,
    GAP  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic                w_q, w_d;

  // w_d is the value w must show in the cycle after this edge, so each branch
  // computes it from the state being entered, keeping w a plain flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    w_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d = PRE;
          cnt_d   = C_PRE;
          sr_d    = load_data;
          w_d     = 1'b1;
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = C_DATA;
          w_d     = sr_q[DATA_W-1];
          sr_d    = sr_q << 1;
        end else begin
          cnt_d = cnt_q - C_ONE;
          w_d   = 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = C_GAP;
        end else begin
          cnt_d = cnt_q - C_ONE;
          w_d   = sr_q[DATA_W-1];
          sr_d  = sr_q << 1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      w_q     <= w_d;
    end
  end

  assign State      = state_q;
  assign w          = w_q;
  assign load_ready = (state_q == IDLE);
  assign done       = (state_q == GAP) && (cnt_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_w_serial_tx.sv
`default_nettype none
// Bench for w_serial_tx: three parameterisations checked every cycle against a
// frame-offset model, plus literal waveform checks of the directed frames.
module tb_w_serial_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  lv;
  logic [7:0]  ld0;
  logic        ld1;
  logic [15:0] ld2;
  logic [2:0]  w_o, rdy_o, dn_o;
  logic [1:0]  st0, st1, st2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  w_serial_tx #(.DATA_W(8), .PRE_LEN(2), .GAP_LEN(1)) u_a (
    .clk(clk), .Reset(rst_n), .load_valid(lv[0]), .load_data(ld0),
    .load_ready(rdy_o[0]), .w(w_o[0]), .State(st0), .done(dn_o[0]));

  w_serial_tx #(.DATA_W(1), .PRE_LEN(1), .GAP_LEN(3)) u_b (
    .clk(clk), .Reset(rst_n), .load_valid(lv[1]), .load_data(ld1),
    .load_ready(rdy_o[1]), .w(w_o[1]), .State(st1), .done(dn_o[1]));

  w_serial_tx #(.DATA_W(16), .PRE_LEN(1), .GAP_LEN(3)) u_c (
    .clk(clk), .Reset(rst_n), .load_valid(lv[2]), .load_data(ld2),
    .load_ready(rdy_o[2]), .w(w_o[2]), .State(st2), .done(dn_o[2]));

  function automatic int pre_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int dw_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 1 : 16);
  endfunction
  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic logic [1:0] st_sel(input int i);
    return (i == 0) ? st0 : ((i == 1) ? st1 : st2);
  endfunction
  function automatic logic [15:0] ld_of(input int i);
    return (i == 0) ? {8'h00, ld0} : ((i == 1) ? {15'h0, ld1} : ld2);
  endfunction

  task automatic set_ld(input int i, input logic [15:0] d);
    if (i == 0) ld0 = d[7:0];
    else if (i == 1) ld1 = d[0];
    else ld2 = d;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: a frame is fully described by its accept edge and captured word.
  int          cyc = 0;
  int          start [3];
  logic [2:0]  act;
  logic [15:0] mdata [3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if ((!act[i] || (cyc - start[i]) >= pre_of(i) + dw_of(i) + gap_of(i)) && lv[i]) begin
          act[i]   <= 1'b1;
          start[i] <= cyc + 1;
          mdata[i] <= ld_of(i);
        end
      end
    end
  end

  task automatic expect_of(input int i, output logic ew, output logic [1:0] es,
                           output logic ed, output logic er);
    int p, d, f, off;
    p = pre_of(i);
    d = dw_of(i);
    f = p + d + gap_of(i);
    off = cyc - start[i];
    ew = 1'b0; es = 2'd0; ed = 1'b0; er = 1'b1;
    if (act[i] && off < f) begin
      er = 1'b0;
      if (off < p) begin
        ew = 1'b1; es = 2'd1;
      end else if (off < p + d) begin
        ew = mdata[i][d-1-(off-p)]; es = 2'd2;
      end else begin
        es = 2'd3; ed = (off == f - 1);
      end
    end
  endtask

  always @(negedge clk) begin
    logic ew, ed, er;
    logic [1:0] es;
    for (int i = 0; i < 3; i++) begin
      expect_of(i, ew, es, ed, er);
      check($sformatf("dut%0d_w", i),     64'(w_o[i]),    64'(ew));
      check($sformatf("dut%0d_state", i), 64'(st_sel(i)), 64'(es));
      check($sformatf("dut%0d_done", i),  64'(dn_o[i]),   64'(ed));
      check($sformatf("dut%0d_ready", i), 64'(rdy_o[i]),  64'(er));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_frame(input int i, input logic [15:0] d, input int n,
                           output logic [31:0] wv, output logic [31:0] dv,
                           output logic [63:0] sv);
    wv = '0; dv = '0; sv = '0;
    lv[i] = 1'b1;
    set_ld(i, d);
    @(posedge clk);
    #2;
    lv[i] = 1'b0;
    set_ld(i, ~d);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      wv = {wv[30:0], w_o[i]};
      dv = {dv[30:0], dn_o[i]};
      sv = {sv[61:0], st_sel(i)};
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wv, dv;
    logic [63:0] sv;
    rst_n = 1'b0; lv = 3'b000; ld0 = '0; ld1 = 1'b0; ld2 = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check("idle_state", 64'(st0), 64'(2'b00));
    check("idle_ready", 64'(rdy_o[0]), 64'(1'b1));

    // Single frame 0xA5 with defaults.
    run_frame(0, 16'h00A5, 11, wv, dv, sv);
    check("a5_w",     64'(wv[10:0]), 64'(11'b11101001010));
    check("a5_done",  64'(dv[10:0]), 64'(11'b00000000001));
    check("a5_state", 64'(sv[21:0]), 64'({2'b01, 2'b01, {8{2'b10}}, 2'b11}));
    step();
    check("a5_ready_back", 64'(rdy_o[0]), 64'(1'b1));

    // Back-to-back with load_valid held high.
    lv[0] = 1'b1; ld0 = 8'hFF;
    @(posedge clk);
    #2 ld0 = 8'h00;
    wv = '0; dv = '0;
    for (int j = 0; j < 23; j++) begin
      @(negedge clk);
      wv = {wv[30:0], w_o[0]};
      dv = {dv[30:0], dn_o[0]};
    end
    lv[0] = 1'b0;
    check("b2b_w",    64'(wv[22:0]), 64'({10'h3FF, 1'b0, 1'b0, 2'b11, 8'h00, 1'b0}));
    check("b2b_done", 64'(dv[22:0]), 64'({10'b0, 1'b1, 11'b0, 1'b1}));

    // Parameter corners.
    step();
    run_frame(1, 16'h0001, 5, wv, dv, sv);
    check("corner1_w",    64'(wv[4:0]), 64'(5'b11000));
    check("corner1_done", 64'(dv[4:0]), 64'(5'b00001));
    step();
    run_frame(2, 16'h8001, 20, wv, dv, sv);
    check("corner16_w", 64'(wv[19:0]), 64'({1'b1, 16'h8001, 3'b000}));

    // Asynchronous reset during the 4th data bit.
    step();
    lv[0] = 1'b1; ld0 = 8'hFF;
    @(posedge clk);
    #2 lv[0] = 1'b0;
    repeat (5) step();
    check("mid_pre_state", 64'(st0), 64'(2'b10));
    check("mid_pre_w",     64'(w_o[0]), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_w",     64'(w_o[0]), 64'(1'b0));
    check("mid_rst_state", 64'(st0), 64'(2'b00));
    check("mid_rst_done",  64'(dn_o[0]), 64'(1'b0));
    check("mid_rst_ready", 64'(rdy_o[0]), 64'(1'b1));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_frame(0, 16'h000F, 11, wv, dv, sv);
    check("post_rst_w", 64'(wv[10:0]), 64'({2'b11, 8'h0F, 1'b0}));

    // Random traffic: handshake toggling, back-to-back and occasional reset.
    step();
    repeat (3000) begin
      step();
      lv  = 3'($urandom);
      ld0 = 8'($urandom);
      ld1 = 1'($urandom);
      ld2 = 16'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1;
    lv = 3'b000;
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/w_serial_tx.md
# w_serial_tx

Serial transmitter for the single-bit `w` stream consumed by the team's sequence-detecting state machines. It accepts a parallel word over a valid/ready handshake and frames it as a serial stream on `w`: a preamble of ones, the data bits MSB-first, then a gap of zeros. Its binary-encoded control FSM is exported on `State` for debug and scoreboarding. It is the driving end of the `w` interface and sits directly upstream of the detector FSMs in the state-machine test fabric.

## Interface
- `DATA_W`, default 8, number of data bits per frame (legal: ≥1).
- `PRE_LEN`, default 2, preamble length in cycles; `w`=1 throughout (legal: ≥1).
- `GAP_LEN`, default 1, trailing gap length in cycles; `w`=0 throughout (legal: ≥1).
- `clk`  input  1  single clock; all state changes on its rising edge.
- `Reset`  input  1  asynchronous, active-low reset.
- `load_valid`  input  1  a word is offered on `load_data`.
- `load_data`  input  DATA_W  word to transmit; sampled only on the accept edge.
- `load_ready`  output  1  block can accept a word; high only in IDLE.
- `w`  output  1  registered serial output.
- `State`  output  2  current FSM state, binary encoded.
- `done`  output  1  one-cycle pulse during the final gap cycle of a frame.

## Operation
- States: IDLE=00, PRE=01, DATA=10, GAP=11. Encoding is fixed; a verification model reads `State` directly.
- Accept: a rising edge with `load_valid`=1 and `load_ready`=1 captures `load_data` into the shift register, loads the down-counter with PRE_LEN-1, and moves IDLE→PRE.
- PRE: `w`=1. When the counter reaches 0, load DATA_W-1 and go to DATA.
- DATA: `w` = shift-register MSB. Shift left by one each cycle. When the counter reaches 0, load GAP_LEN-1 and go to GAP.
- GAP: `w`=0. `done`=1 in the cycle where the counter is 0. Go to IDLE on that edge.
- IDLE: `w`=0, `done`=0. `load_valid` with no accept has no effect.
- `load_ready` = (State==IDLE), decoded combinationally. `done` is decoded from state and counter. `w` comes from a flop.
- Counter width: clog2(max(PRE_LEN, DATA_W, GAP_LEN)), minimum 1 bit. It never wraps: each phase reloads it at its boundary.
- `load_data` changes outside the accept edge are ignored, and so is `load_valid` during a frame. There is no abort input.
- Reset (`Reset`=0) takes effect immediately, including mid-frame:
  - State=IDLE, `w`=0, `done`=0, counter=0, shift register=0.
  - `load_ready` reads 1, but no accept occurs while `Reset`=0.
  - The first accept is possible on the first rising edge after `Reset` returns to 1.

## Timing
- Accept on edge k. Then `w`=1 for cycles k..k+PRE_LEN-1 (a cycle n is the period after edge n).
- Data bit DATA_W-1-i is on `w` in cycle k+PRE_LEN+i.
- Gap cycles: k+PRE_LEN+DATA_W … k+PRE_LEN+DATA_W+GAP_LEN-1. `done` is high in the last of these.
- Frame length F = PRE_LEN+DATA_W+GAP_LEN cycles. `load_ready` returns to 1 in cycle k+F.
- Back-to-back: the earliest next accept is edge k+F+1. The minimum inter-frame period is F+1 cycles, so `w` has at least GAP_LEN+1 zeros between frames.
- Latency from accept to the first data bit: PRE_LEN cycles.

## Test plan
- Reset then idle: hold `Reset`=0 for 3 cycles and release, with no `load_valid`. Required: `State`=00, `w`=0, `load_ready`=1, `done`=0 on every cycle.
- Single frame, defaults, `load_data`=0xA5. Required: `w` over cycles k..k+10 = 1,1,1,0,1,0,0,1,0,1,0. `State` = 01,01,10×8,11. `done`=1 only in cycle k+10. `load_ready`=1 again in k+11.
- Back-to-back: hold `load_valid`=1 with 0xFF then 0x00. Required: second accept at k+12. `w` = 1×10, 0, 0, 1, 1, 0×8, 0. Exactly one `done` per frame.
- Parameter corners: PRE_LEN=1, GAP_LEN=3, DATA_W=1, data=1. Required: `w` = 1, 1, 0, 0, 0 with `done` in the 5th cycle; then DATA_W=16, 0x8001 gives MSB first, then 14 zeros, then 1.
- Reset mid-frame: assert `Reset`=0 asynchronously during the 4th data bit of 0xFF. Required: `w`=0 and `State`=00 before the next clock edge, and no `done`. After release, a new accept of 0x0F produces a correct full frame.
- Handshake hold-off: toggle `load_valid` and `load_data` every cycle during a frame. Required: the transmitted bits match the word captured at the accept edge, and no further accept occurs before `load_ready`=1.
